// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control unit for a multicycle MIPS-subset datapath.
//
// Supported instructions: R-type, ori, addiu, lui, lw, sw, beq, j.
// The controller is a Moore/Mealy FSM: the state register advances on clk,
// and all control outputs are decoded combinationally from the current
// state, op, zero and mem_ready.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset; forces all outputs to 0
//   op[5:0]    in   opcode field of the instruction register
//   funct[5:0] in   funct field; the datapath ALU decoder consumes it directly
//   zero       in   ALU zero flag (beq condition)
//   mem_ready  in   memory handshake; an access completes when high
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, ExtOp, illegal_op
//   RegDst[1:0], DatatoReg[1:0], ALUOp[1:0], PCSrc[1:0]
//
// Optional feature (macro MC_CTRL_PERF_EN):
//   cycle_cnt[31:0]  cycles spent out of reset
//   instr_cnt[31:0]  completed instructions (entries into FETCH, illegal included)

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic       illegal_op,
    output logic [1:0] RegDst,
    output logic [1:0] DatatoReg,
    output logic [1:0] ALUOp,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    output logic [1:0] PCSrc
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I,
        MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
    } state_t;

    state_t state, next_state;

    // funct selects the ALU operation in the datapath; the FSM never needs it.
    logic unused_funct;
    assign unused_funct = ^funct;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        illegal_op = 1'b0;
        RegDst     = 2'b00;
        DatatoReg  = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;

        unique case (state)
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    OP_RTYPE:                next_state = EXEC_R;
                    OP_ORI, OP_ADDIU, OP_LUI: next_state = EXEC_I;
                    OP_LW, OP_SW:            next_state = MEM_ADDR;
                    OP_BEQ:                  next_state = BRANCH;
                    OP_J:                    next_state = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                ALUOp      = 2'b10;
                next_state = WB_R;
            end
            WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                next_state = FETCH;
            end
            EXEC_I: begin
                // lui needs only the immediate routed; the ALU result is unused.
                ALUSrc = 1'b1;
                if (op == OP_ORI) begin
                    ALUOp = 2'b11;
                end else if (op == OP_ADDIU) begin
                    ExtOp = 1'b1;
                end
                next_state = WB_I;
            end
            WB_I: begin
                RegWrite   = 1'b1;
                DatatoReg  = (op == OP_LUI) ? 2'b10 : 2'b00;
                next_state = FETCH;
            end
            MEM_ADDR: begin
                ALUSrc     = 1'b1;
                ExtOp      = 1'b1;
                next_state = (op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                if (mem_ready) next_state = MEM_WB;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                DatatoReg  = 2'b01;
                next_state = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            BRANCH: begin
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                PCWrite    = zero;
                next_state = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        // Reset silences the datapath immediately, not one edge later.
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            ALUSrc     = 1'b0;
            ExtOp      = 1'b0;
            illegal_op = 1'b0;
            RegDst     = 2'b00;
            DatatoReg  = 2'b00;
            ALUOp      = 2'b00;
            PCSrc      = 2'b00;
        end
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state != FETCH && next_state == FETCH)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
